image_loader: RTL
=================

# image_loader

Front-end stage of the CNN datapath. It accepts a row-major stream of 8-bit pixels over a valid/ready handshake and assembles one 28×28 frame in a register buffer. It converts each pixel to the 32-bit signed data word consumed by `conv_layer`, then holds the frame stable with `frame_valid` asserted until the consumer acknowledges it. It replaces the static `read_data` image source and is the block that drives the convolution stage's `data` array and `conv_enable`.

## Interface
- `DATA_X`, 28: frame rows.
- `DATA_Y`, 28: frame columns.
- `PIX_W`, 8: input pixel width, unsigned.
- `DATA_W`, 32: output word width, signed.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset; synchronous, active-high.
- `pix_valid`, in, 1: pixel beat valid.
- `pix_data`, in, `PIX_W`: pixel value.
- `pix_last`, in, 1: producer's end-of-frame marker.
- `pix_ready`, out, 1: loader accepts a beat.
- `data`, out, `DATA_W` × [`DATA_X`][`DATA_Y`]: frame buffer, indexed `data[row][col]`.
- `frame_valid`, out, 1: complete frame held. Drives `conv_enable`.
- `frame_ack`, in, 1: consumer releases the frame.
- `frame_err`, out, 1: one-cycle pulse on a framing error.
- `frame_cnt`, out, 8: count of committed frames; wraps 255→0.

## Operation
- States are `LOAD` and `FULL`. Reset enters `LOAD`.
- A beat is accepted when `pix_valid & pix_ready`. `pix_ready` = (state == `LOAD`).
- `LOAD`:
  - Each accepted beat writes `data[row][col]`.
  - `col` increments. At `DATA_Y-1`, `col` wraps to 0 and `row` increments.
- The final beat is the beat with `row==DATA_X-1` and `col==DATA_Y-1`.
  - Accepting it moves the state to `FULL`, zeroes `row`/`col`, and increments `frame_cnt`.
  - If `pix_last` is low on this beat, `frame_err` pulses and the frame is still committed.
- An accepted beat with `pix_last` high that is not the final beat is a short frame:
  - `frame_err` pulses.
  - `row`/`col` clear to 0 and the state stays `LOAD`.
  - The partial frame is discarded. Buffer words already written stay until overwritten.
- `FULL`:
  - `frame_valid` = 1, `pix_ready` = 0, and the buffer is frozen.
  - `frame_ack` moves the state to `LOAD`.
- `frame_ack` is ignored in `LOAD`.
- Pixel conversion depends on the configuration macro below. The result is always non-negative and zero-extended to `DATA_W`.

## Timing
- Reset values:
  - State `LOAD`, `pix_ready` 1, `frame_valid` 0, `frame_err` 0, `frame_cnt` 0.
  - `row`/`col` 0 and all `data` words 0.
- A write is visible on `data` in the cycle after the beat is accepted.
- `frame_valid` rises in the cycle after the final beat is accepted, so a full frame costs 784 accepted beats plus 1 cycle.
- `frame_ack` sampled high in `FULL` gives `frame_valid`=0 and `pix_ready`=1 in the next cycle. The earliest next beat is accepted in that cycle.
- `frame_err` is registered and asserts in the cycle after the offending beat.
- `pix_valid` may toggle freely. Gaps stall the counters with no data loss.
- A `rst` assertion mid-frame or in `FULL` returns all state to reset values at the next edge. Any partial frame is lost.
- `frame_ack` and `pix_valid` high in the same `FULL` cycle: the ack is taken, and the pixel is not accepted until the following cycle.

## Configuration
- Macro `PIX_SCALE_EN`.
- Defined: `data` word = `pix_data << 8`, i.e. Q24.8 fixed point with the pixel as the integer part.
- Undefined: `data` word = `pix_data` zero-extended.
- Both handshake and timing behaviour are identical either way.

## Structure
- Shared package `cnn_pkg` holds:
  - Constants `DATA_X`, `DATA_Y`, `DATA_SIZE`.
  - Typedef `loader_state_t` (`LOAD`, `FULL`).
  - Typedef `data_word_t` (signed `DATA_W`).
- One sub-module, `pix_addr_counter`:
  - Row/col counter with enable and clear.
  - Wrap at `DATA_Y-1`.
  - Combinational `is_final` flag.
- The top-level `image_loader` holds the FSM, the buffer, error detection and the frame counter.

## Test plan
- Stream 784 beats with values `(row*28+col)&8'hFF` and `pix_last` on beat 784 → `frame_valid`=1 one cycle after the last beat; `data[27][27]`=`0x0F` (`0xF00` with `PIX_SCALE_EN`); `frame_cnt`=1.
- Same stream with `pix_valid` low every other cycle → identical buffer; `frame_valid` rises one cycle after the last accepted beat.
- In `FULL`, hold `pix_valid`=1 for 10 cycles, then pulse `frame_ack` → no beats accepted before the ack; `pix_ready`=1 the cycle after the ack; the next beat writes `data[0][0]`.
- Assert `pix_last` on beat 100 → `frame_err` pulses once; the next beat writes `data[0][0]`; `frame_valid` stays 0.
- Send 784 beats without `pix_last` → `frame_err` pulses; `frame_valid`=1; `frame_cnt` increments.
- Assert `rst` at beat 400, then send a full frame → all outputs return to reset values; the frame completes normally with `frame_cnt`=1. Separately, 256 commits → `frame_cnt` wraps to 0.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN datapath front end.
// Buffer geometry, pixel/word widths and the image loader state encoding.
package cnn_pkg;

  localparam int DATA_X    = 28;
  localparam int DATA_Y    = 28;
  localparam int DATA_SIZE = DATA_X * DATA_Y;
  localparam int PIX_W     = 8;
  localparam int DATA_W    = 32;
  localparam int ROW_W     = $clog2(DATA_X);
  localparam int COL_W     = $clog2(DATA_Y);

  typedef enum logic {
    LOAD = 1'b0,
    FULL = 1'b1
  } loader_state_t;

  typedef logic signed [DATA_W-1:0] data_word_t;

endpackage

// File: rtl/pix_addr_counter.sv
// Row-major write address for the frame buffer: col wraps at DATA_Y-1 into row.
// Clear has priority over enable; is_final flags the last cell of the frame.
module pix_addr_counter
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             is_final
);

  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (en) begin
      if (col_q == COL_W'(DATA_Y - 1)) begin
        col_d = '0;
        row_d = row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row      = row_q;
  assign col      = col_q;
  assign is_final = (row_q == ROW_W'(DATA_X - 1)) && (col_q == COL_W'(DATA_Y - 1));

endmodule

// File: rtl/image_loader.sv
// Assembles a 28x28 pixel stream into a held frame buffer for conv_layer.
// Build option: define PIX_SCALE_EN to store pixels as Q24.8 (pixel << 8).
module image_loader
  import cnn_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             pix_valid,
  input  logic [PIX_W-1:0] pix_data,
  input  logic             pix_last,
  output logic             pix_ready,
  output data_word_t       data [DATA_X][DATA_Y],
  output logic             frame_valid,
  input  logic             frame_ack,
  output logic             frame_err,
  output logic [7:0]       frame_cnt
);

  loader_state_t    state_q, state_d;
  logic             pix_ready_q, pix_ready_d;
  logic             frame_valid_q, frame_valid_d;
  logic             frame_err_q, frame_err_d;
  logic [7:0]       frame_cnt_q, frame_cnt_d;
  data_word_t       data_q [DATA_X][DATA_Y];
  data_word_t       pix_word;
  logic             accept;
  logic             addr_clr;
  logic             is_final;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;

`ifdef PIX_SCALE_EN
  assign pix_word = data_word_t'({{(DATA_W-PIX_W-8){1'b0}}, pix_data, 8'h00});
`else
  assign pix_word = data_word_t'({{(DATA_W-PIX_W){1'b0}}, pix_data});
`endif

  // pix_ready_q is only high in LOAD, so accept implies the buffer is writable.
  assign accept   = pix_valid & pix_ready_q;
  assign addr_clr = accept & (is_final | pix_last);

  pix_addr_counter u_addr (
    .clk      (clk),
    .rst      (rst),
    .en       (accept),
    .clr      (addr_clr),
    .row      (row),
    .col      (col),
    .is_final (is_final)
  );

  always_comb begin
    state_d     = state_q;
    frame_err_d = 1'b0;
    frame_cnt_d = frame_cnt_q;
    case (state_q)
      LOAD: begin
        if (accept) begin
          if (is_final) begin
            state_d     = FULL;
            frame_cnt_d = frame_cnt_q + 8'd1;
            frame_err_d = ~pix_last;
          end else if (pix_last) begin
            frame_err_d = 1'b1;
          end
        end
      end
      FULL: begin
        if (frame_ack) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    pix_ready_d   = (state_d == LOAD);
    frame_valid_d = (state_d == FULL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= LOAD;
      pix_ready_q   <= 1'b1;
      frame_valid_q <= 1'b0;
      frame_err_q   <= 1'b0;
      frame_cnt_q   <= 8'd0;
    end else begin
      state_q       <= state_d;
      pix_ready_q   <= pix_ready_d;
      frame_valid_q <= frame_valid_d;
      frame_err_q   <= frame_err_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DATA_X; r++) begin
        for (int c = 0; c < DATA_Y; c++) begin
          data_q[r][c] <= '0;
        end
      end
    end else if (accept) begin
      data_q[row][col] <= pix_word;
    end
  end

  assign data        = data_q;
  assign pix_ready   = pix_ready_q;
  assign frame_valid = frame_valid_q;
  assign frame_err   = frame_err_q;
  assign frame_cnt   = frame_cnt_q;

endmodule
